// File: rtl/seven_segments_reader.sv
// Loopback decoder for a multiplexed active-high 7-segment bus: qualifies each strobed digit,
// decodes it back to a nibble and publishes the whole frame. Optional macro: SEVEN_SEGMENTS_READER_BLANK_EN.
module seven_segments_reader #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   value,
  output logic                  frame_valid,
  output logic                  invalid_digit,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  dbg_state
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1) + 1;
  localparam int unsigned SW = DIGITS + 7;

  typedef enum logic {
    TRACK = 1'b0,
    HELD  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       s_q;
  logic [CW-1:0]       c_q, c_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [DIGITS-1:0]   blank_sh_q, blank_sh_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic                fv_q, fv_d;
  logic                inv_q, inv_d;

  logic [SW-1:0]       sample;
  logic                same;
  logic [31:0]         run_len;
  logic                stable_hit;
  logic                sel_onehot;
  logic                capture;
  logic [3:0]          nib;
  logic                known;
  logic                is_blank;

  assign sample     = {dig_sel, seg_in};
  assign same       = (sample == s_q);
  // Length of the run of identical samples including the one taken at this edge.
  assign run_len    = same ? (32'(c_q) + 32'd2) : 32'd1;
  assign stable_hit = (run_len >= 32'(STABLE_CYCLES));
  assign sel_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
  // In HELD a capture is only possible when the changing sample itself qualifies.
  assign capture    = stable_hit && sel_onehot && ((state_q == TRACK) || !same);

  always_comb begin
    nib      = 4'hF;
    known    = 1'b0;
    is_blank = 1'b0;
    case (seg_in)
      7'h3F: begin nib = 4'h0; known = 1'b1; end
      7'h06: begin nib = 4'h1; known = 1'b1; end
      7'h5B: begin nib = 4'h2; known = 1'b1; end
      7'h4F: begin nib = 4'h3; known = 1'b1; end
      7'h66: begin nib = 4'h4; known = 1'b1; end
      7'h6D: begin nib = 4'h5; known = 1'b1; end
      7'h7D: begin nib = 4'h6; known = 1'b1; end
      7'h07: begin nib = 4'h7; known = 1'b1; end
      7'h7F: begin nib = 4'h8; known = 1'b1; end
      7'h6F: begin nib = 4'h9; known = 1'b1; end
      7'h79: begin nib = 4'hE; known = 1'b1; end
`ifdef SEVEN_SEGMENTS_READER_BLANK_EN
      7'h00: begin nib = 4'h0; known = 1'b1; is_blank = 1'b1; end
`endif
      default: begin nib = 4'hF; known = 1'b0; end
    endcase
  end

  always_comb begin
    if (!same) begin
      c_d = '0;
    end else if (c_q >= CW'(STABLE_CYCLES)) begin
      c_d = c_q;
    end else begin
      c_d = c_q + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (capture) begin
      state_d = HELD;
    end else if ((state_q == HELD) && !same) begin
      state_d = TRACK;
    end
  end

  always_comb begin
    shadow_d   = shadow_q;
    blank_sh_d = blank_sh_q;
    mask_d     = mask_q;
    value_d    = value_q;
    blank_d    = blank_q;
    fv_d       = 1'b0;
    inv_d      = 1'b0;
    if (capture) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (dig_sel[i]) begin
          shadow_d[4*i +: 4] = nib;
          blank_sh_d[i]      = is_blank;
        end
      end
      mask_d = mask_q | dig_sel;
      inv_d  = !known;
      // Completing capture publishes the frame, new nibble included, and starts a fresh one.
      if (&mask_d) begin
        value_d = shadow_d;
        blank_d = blank_sh_d;
        fv_d    = 1'b1;
        mask_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= TRACK;
      s_q        <= '0;
      c_q        <= '0;
      mask_q     <= '0;
      shadow_q   <= '0;
      blank_sh_q <= '0;
      value_q    <= '0;
      blank_q    <= '0;
      fv_q       <= 1'b0;
      inv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= sample;
      c_q        <= c_d;
      mask_q     <= mask_d;
      shadow_q   <= shadow_d;
      blank_sh_q <= blank_sh_d;
      value_q    <= value_d;
      blank_q    <= blank_d;
      fv_q       <= fv_d;
      inv_q      <= inv_d;
    end
  end

  assign value         = value_q;
  assign frame_valid   = fv_q;
  assign invalid_digit = inv_q;
  assign blank_mask    = blank_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/seven_segments_reader.md
Name: seven_segments_reader

Overview:
- Sniffs a multiplexed, active-high 7-segment display bus (one shared segment bus plus one-hot digit strobes) and reconstructs the multi-digit binary value.
- Each strobed pattern must be held stable for a fixed number of cycles before it is accepted; it is then decoded back to a 4-bit code.
- A one-cycle valid pulse is raised once every digit of a frame has been captured.
- Sits on the display side of the counter as the self-check / loopback decoder for the segment encoder.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a capture (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- seg_in  input  7  segment bus; bit0=top, bit1=upper-right, bit2=lower-right, bit3=bottom, bit4=lower-left, bit5=upper-left, bit6=middle; 1 = lit
- dig_sel  input  DIGITS  digit strobe, one-hot; bit i = digit i (digit 0 least significant)
- value  output  4*DIGITS  decoded frame; nibble i = digit i
- frame_valid  output  1  one-cycle pulse; value updated this cycle
- invalid_digit  output  1  one-cycle pulse on capture of an unrecognised pattern
- blank_mask  output  DIGITS  per-digit blank flags for the last frame (see Optional Feature)

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset: value=0, frame_valid=0, invalid_digit=0, blank_mask=0, captured mask=0, stability counter=0, FSM=TRACK.
  - Reset asserted mid-frame discards all partially captured digits.
- Sample register s holds {dig_sel, seg_in}.
  - Every edge: s <= inputs.
  - Counter c: if inputs == s then c <= c+1 (saturating at STABLE_CYCLES), else c <= 0.
- FSM:
  - TRACK: capture on the edge that takes the STABLE_CYCLES-th consecutive identical sample, provided dig_sel is exactly one-hot; then go to HELD.
  - Timing example: inputs applied before edge 0 and held, STABLE_CYCLES=4 -> capture at edge 3.
  - HELD: no further capture. Return to TRACK on the first edge where inputs differ from s (c restarts at 0). The same strobe is never captured twice without a change.
  - dig_sel zero or multi-hot: never captured; FSM stays in / returns to TRACK.
- Decode table (seg_in[6:0] -> nibble), unrecognised patterns -> 4'hF:
  - 0111111->0, 0000110->1, 1011011->2, 1001111->3, 1100110->4
  - 1101101->5, 1111101->6, 0000111->7, 1111111->8, 1101111->9
  - 1111001->E (the "error" glyph; valid capture, no invalid_digit)
- On an unrecognised-pattern capture: invalid_digit pulses high for one cycle in the cycle after the capture edge; the slot still stores 4'hF and counts as captured.
- Capture writes the decoded nibble into a shadow slot and sets captured-mask bit i. Recapture of an already-set digit before frame completion overwrites its shadow slot.
- Frame completion: on the capture edge that makes the mask all-ones, in the same edge:
  - value <= shadow (including the new nibble)
  - blank_mask <= shadow blanks
  - frame_valid <= 1 for exactly one cycle
  - mask <= 0
- value and blank_mask hold between frames.
- Input change during HELD followed by the same pattern again requires a full STABLE_CYCLES re-qualification.

Optional Feature:
- Macro: SEVEN_SEGMENTS_READER_BLANK_EN.
- Defined: pattern 0000000 is a valid blank digit. It decodes to 4'h0, sets its blank_mask bit, and does not pulse invalid_digit.
- Undefined: 0000000 is unrecognised (4'hF, invalid_digit pulse); blank_mask is tied to 0.

Test Plan:
- Reset, then DIGITS=4, STABLE_CYCLES=4. Strobe digits 0..3 with patterns 3,7,0,9, each held 6 cycles -> frame_valid pulses once at digit-3 capture edge; value=16'h9073.
- Hold dig_sel=0001, seg_in=0000110 for 3 cycles then change -> no capture. Hold 4 cycles -> digit 0 captured at 4th sample edge; holding 20 more cycles causes no recapture.
- Capture pattern 1010101 on digit 2 -> invalid_digit one-cycle pulse; completed frame has nibble 2 = 4'hF. Pattern 1111001 -> nibble 4'hE, no invalid_digit.
- dig_sel=0011 or 0000 held 10 cycles with valid segments -> no capture, no frame_valid, mask unchanged.
- Capture digits 0-2, assert reset 1 cycle, then capture digit 3 only -> no frame_valid. A full new 4-digit sequence is then required; value remains 0 until it completes.
- With SEVEN_SEGMENTS_READER_BLANK_EN, strobe 0000000 on digit 3 plus 1,2,3 on digits 0-2 -> value=16'h0321, blank_mask=4'b1000, no invalid_digit. Without the macro -> value=16'hF321, invalid_digit pulse, blank_mask=0.
